// File: rtl/la_spram_bist_if.sv
// la_spram_bist_if: single-port RAM bus between the BIST engine (master) and the RAM (slave).
interface la_spram_bist_if #(
   parameter int DW = 32,
   parameter int AW = 10
);
   logic          ce;
   logic          we;
   logic [DW-1:0] wmask;
   logic [AW-1:0] addr;
   logic [DW-1:0] din;
   logic [DW-1:0] dout;
   modport master(output ce, we, wmask, addr, din, input dout);
   modport slave(input ce, we, wmask, addr, din, output dout);
endinterface

// File: rtl/la_spram_bist.sv
// la_spram_bist: March C- self-test engine driving one single-port RAM.
// Define LA_SPRAM_BIST_ERRCNT_EN to count every mismatch and always run to completion.
module la_spram_bist #(
   parameter int DW = 32,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          fail,
   output logic [AW-1:0] fail_addr,
   output logic [2:0]    fail_elem,
`ifdef LA_SPRAM_BIST_ERRCNT_EN
   output logic [15:0]   err_count,
`endif
   la_spram_bist_if.master mem
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
   state_t        state, state_nx;
   logic [2:0]    elem;
   logic [AW-1:0] addr;
   logic          ph;
   logic          rd_v;
   logic [DW-1:0] exp_d;
   logic [AW-1:0] exp_a;
   logic [2:0]    exp_e;
   logic          run, go, two_op, wr, up, last_a, last, mism, ce;
   always_comb begin
      run    = state == RUN;
      go     = start && (state == IDLE || state == DONE);
      two_op = elem != 3'd0 && elem != 3'd5;
      wr     = elem == 3'd0 || (two_op && ph);
      up     = elem < 3'd3;
      last_a = up ? addr == {AW{1'b1}} : addr == '0;
      last   = last_a && (ph || !two_op);
      mism   = rd_v && mem.dout != exp_d;
   end
   always_ff @(posedge clk)
      if (reset) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = go ? RUN :
                 state == DRAIN ? DONE :
                 (run && last && elem == 3'd5) ? DRAIN : state;
`ifndef LA_SPRAM_BIST_ERRCNT_EN
      if (mism) state_nx = DONE;
`endif
   end
   always_comb begin
`ifdef LA_SPRAM_BIST_ERRCNT_EN
      ce = run;
`else
      ce = run && !mism;
`endif
      busy      = state == RUN || state == DRAIN;
      done      = state == DONE;
      mem.ce    = ce;
      mem.we    = ce && wr;
      mem.wmask = busy ? '1 : '0;
      mem.addr  = run ? addr : '0;
      mem.din   = (run && elem[0]) ? '1 : '0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         elem      <= '0;
         addr      <= '0;
         ph        <= 1'b0;
         rd_v      <= 1'b0;
         exp_d     <= '0;
         exp_a     <= '0;
         exp_e     <= '0;
         fail      <= 1'b0;
         fail_addr <= '0;
         fail_elem <= '0;
`ifdef LA_SPRAM_BIST_ERRCNT_EN
         err_count <= '0;
`endif
      end else begin
         rd_v  <= ce && !wr;
         exp_d <= (elem == 3'd2 || elem == 3'd4) ? '1 : '0;
         exp_a <= addr;
         exp_e <= elem;
         if (go) begin
            elem      <= '0;
            addr      <= '0;
            ph        <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= '0;
`ifdef LA_SPRAM_BIST_ERRCNT_EN
            err_count <= '0;
`endif
         end else begin
            if (run) begin
               if (two_op && !ph) ph <= 1'b1;
               else begin
                  ph <= 1'b0;
                  // next element reloads the counter at its own start end
                  if (last_a) begin
                     elem <= elem + 3'd1;
                     addr <= elem >= 3'd2 ? '1 : '0;
                  end else addr <= up ? addr + 1'b1 : addr - 1'b1;
               end
            end
            if (mism && !fail) begin
               fail      <= 1'b1;
               fail_addr <= exp_a;
               fail_elem <= exp_e;
            end
`ifdef LA_SPRAM_BIST_ERRCNT_EN
            if (mism && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
         end
      end
   end
endmodule

// File: tb/tb_la_spram_bist.sv
// tb_la_spram_bist: scoreboard bench for la_spram_bist with a faulty-capable 1-cycle RAM model.
module tb_la_spram_bist;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done, fail;
   logic [2:0] fail_addr, fail_elem;
`ifdef LA_SPRAM_BIST_ERRCNT_EN
   logic [15:0] err_count;
`endif
   always #5 clk = ~clk;
   la_spram_bist_if #(.DW(8), .AW(3)) mem ();
   la_spram_bist #(.DW(8), .AW(3)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .fail(fail),
      .fail_addr(fail_addr), .fail_elem(fail_elem),
`ifdef LA_SPRAM_BIST_ERRCNT_EN
      .err_count(err_count),
`endif
      .mem(mem.master)
   );
   logic [7:0] ram [8];
   int fault = 0;
   function automatic logic [7:0] rd(input logic [2:0] a);
      logic [7:0] v;
      v = ram[a];
      if (fault == 1 && a == 3'd5) v = v | 8'h04;
      if (fault == 3 && a == 3'd5) v = v & 8'hFE;
      return v;
   endfunction
   always @(posedge clk)
      if (mem.ce) begin
         if (mem.we) begin
            ram[mem.addr] <= (mem.din & mem.wmask) | (ram[mem.addr] & ~mem.wmask);
            if (fault == 2 && mem.addr == 3'd3) ram[7] <= mem.din;
         end else mem.dout <= rd(mem.addr);
      end
   int tests = 0, fails = 0, cyc = 0, s = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   typedef struct {int c; logic f; logic [2:0] fa; logic [2:0] fe; logic [15:0] ec;} res_t;
   typedef struct {logic we; logic [2:0] a; logic [7:0] d;} op_t;
   res_t rq[$];
   op_t  oq[$];
   bit   chk_ops = 0;
   logic done_q = 1'b0;
   task automatic push_ops();
      for (int e = 0; e < 6; e++)
         for (int i = 0; i < 8; i++) begin
            logic [2:0] a;
            a = (e < 3) ? 3'(i) : 3'(7 - i);
            if (e > 0) oq.push_back('{1'b0, a, 8'h00});
            if (e < 5) oq.push_back('{1'b1, a, (e % 2) ? 8'hFF : 8'h00});
         end
   endtask
   always @(negedge clk) begin
      if (chk_ops && mem.ce) begin
         if (oq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL op_extra: got op at addr %0d, expected none", mem.addr);
         end else begin
            op_t o;
            o = oq.pop_front();
            chk("op_we", mem.we, o.we);
            chk("op_addr", mem.addr, o.a);
            chk("op_wmask", mem.wmask, 8'hFF);
            if (o.we) chk("op_din", mem.din, o.d);
         end
      end
      if (done && !done_q) begin
         if (rq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done_extra: got done, expected none");
         end else begin
            res_t r;
            r = rq.pop_front();
            chk("done_cycle", cyc - s + 1, r.c);
            chk("done_busy", busy, 0);
            chk("done_fail", fail, r.f);
            if (r.f) begin
               chk("fail_addr", fail_addr, r.fa);
               chk("fail_elem", fail_elem, r.fe);
            end
`ifdef LA_SPRAM_BIST_ERRCNT_EN
            chk("err_count", err_count, r.ec);
`endif
         end
      end
      done_q = done;
   end
   task automatic launch();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      s = cyc;
      start = 1'b0;
   endtask
   task automatic poke(input int k);
      while (cyc - s + 1 < k) @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask
   task automatic wait_done();
      int n = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got done=0 after %0d cycles, expected done=1", n);
      end
      @(negedge clk);
   endtask
   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_fail"}, fail, 0);
      chk({tag, "_faddr"}, fail_addr, 0);
      chk({tag, "_felem"}, fail_elem, 0);
      chk({tag, "_ce"}, mem.ce, 0);
      chk({tag, "_we"}, mem.we, 0);
      chk({tag, "_wmask"}, mem.wmask, 0);
      chk({tag, "_addr"}, mem.addr, 0);
      chk({tag, "_din"}, mem.din, 0);
`ifdef LA_SPRAM_BIST_ERRCNT_EN
      chk({tag, "_errc"}, err_count, 0);
`endif
   endtask
   task automatic clean_run(input string tag);
      push_ops();
      rq.push_back('{82, 1'b0, 3'd0, 3'd0, 16'd0});
      chk_ops = 1;
      launch();
      chk({tag, "_busy1"}, busy, 1);
   endtask
   initial begin
      repeat (3) @(negedge clk);
      chk_idle("rst");
      reset = 1'b0;
      clean_run("s1");
      wait_done();
      chk("s1_opq", oq.size(), 0);
      chk_ops = 0;
`ifndef LA_SPRAM_BIST_ERRCNT_EN
      fault = 1;
      rq.push_back('{21, 1'b1, 3'd5, 3'd1, 16'd0});
      launch();
      wait_done();
      fault = 2;
      rq.push_back('{25, 1'b1, 3'd7, 3'd1, 16'd0});
      launch();
      wait_done();
`endif
      fault = 0;
      launch();
      while (cyc - s + 1 < 20) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk_idle("s4_rst");
      clean_run("s4");
      wait_done();
      chk("s4_opq", oq.size(), 0);
      chk_ops = 0;
      clean_run("s5");
      poke(5);
      poke(40);
      wait_done();
      chk("s5_opq", oq.size(), 0);
      chk_ops = 0;
`ifdef LA_SPRAM_BIST_ERRCNT_EN
      fault = 3;
      rq.push_back('{82, 1'b1, 3'd5, 3'd2, 16'd2});
      launch();
      wait_done();
`endif
      chk("res_q", rq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
   initial begin
      #100000;
      $display("FAIL watchdog: got no finish, expected finish within 100000 time units");
      $fatal(1);
   end
endmodule
